// File: rtl/shift_arbiter_if.sv
// Request/grant/result bundle between the two shift requesters and the
// shared barrel shifter. The master side is the requester pair, and the
// slave side is the arbiter.
interface shift_arbiter_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
);
    logic                   req_a;
    logic                   dir_a;
    logic [DATA_WIDTH-1:0]  data_a;
    logic [SHAMT_WIDTH-1:0] shamt_a;

    logic                   req_b;
    logic                   dir_b;
    logic [DATA_WIDTH-1:0]  data_b;
    logic [SHAMT_WIDTH-1:0] shamt_b;

    logic                   gnt_a;
    logic                   gnt_b;
    logic [DATA_WIDTH-1:0]  result;
    logic                   result_valid;
    logic                   result_src;

    modport master (
        output req_a, dir_a, data_a, shamt_a,
        output req_b, dir_b, data_b, shamt_b,
        input  gnt_a, gnt_b, result, result_valid, result_src
    );

    modport slave (
        input  req_a, dir_a, data_a, shamt_a,
        input  req_b, dir_b, data_b, shamt_b,
        output gnt_a, gnt_b, result, result_valid, result_src
    );
endinterface

// File: rtl/shift_arbiter.sv
// Shared 32-bit barrel shifter for the execute stage. It serves two
// requesters: A is the ALU and B is the multdiv sequencer. Grants are
// round-robin and combinational. One operation is accepted per cycle.
// Each result is registered one cycle later and tagged with its source.
module shift_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic            clock,
    input  logic            reset,
    shift_arbiter_if.slave  bus
);

    // last_gnt records which requester won most recently. On a tie, the
    // other requester wins.
    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_t;

    last_t                  last_gnt;
    last_t                  last_gnt_next;

    logic                   gnt_a;
    logic                   gnt_b;

    logic                   op_dir;
    logic [DATA_WIDTH-1:0]  op_data;
    logic [SHAMT_WIDTH-1:0] op_shamt;
    logic [DATA_WIDTH-1:0]  shifted;

    logic [DATA_WIDTH-1:0]  result_q;
    logic                   result_valid_q;
    logic                   result_src_q;

    // Arbitration: a lone requester wins. On a tie, the requester that did
    // not win last time wins. Reset suppresses every grant, so nothing is
    // accepted in a reset cycle.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset) begin
            if (bus.req_a && (!bus.req_b || last_gnt == LAST_B)) begin
                gnt_a = 1'b1;
            end else if (bus.req_b) begin
                gnt_b = 1'b1;
            end
        end
    end

    // Operand mux steers the granted requester's operation into the single
    // shifter. B is selected only when it actually holds the grant.
    always_comb begin
        op_dir   = bus.dir_a;
        op_data  = bus.data_a;
        op_shamt = bus.shamt_a;
        if (gnt_b) begin
            op_dir   = bus.dir_b;
            op_data  = bus.data_b;
            op_shamt = bus.shamt_b;
        end
    end

    // Barrel shift: a left shift fills with zeros. A right shift replicates
    // the sign bit.
    always_comb begin
        shifted = op_data << op_shamt;
        if (op_dir) begin
            shifted = $signed(op_data) >>> op_shamt;
        end
    end

    // Round-robin pointer next state follows whichever requester is granted
    // this cycle. It holds when the cycle is idle.
    always_comb begin
        last_gnt_next = last_gnt;
        if (gnt_a) begin
            last_gnt_next = LAST_A;
        end else if (gnt_b) begin
            last_gnt_next = LAST_B;
        end
    end

    // Round-robin pointer register. Its reset value favours A on the first
    // tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_gnt <= LAST_B;
        end else begin
            last_gnt <= last_gnt_next;
        end
    end

    // Result register: it captures the granted operation. On idle cycles
    // only the valid flag drops. The data and source tag keep their last
    // values.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            result_src_q   <= 1'b0;
        end else if (gnt_a || gnt_b) begin
            result_q       <= shifted;
            result_valid_q <= 1'b1;
            result_src_q   <= gnt_b;
        end else begin
            result_valid_q <= 1'b0;
        end
    end

    assign bus.gnt_a        = gnt_a;
    assign bus.gnt_b        = gnt_b;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_src   = result_src_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Testbench for shift_arbiter. It runs directed scenarios first and then
// randomized requests. Every DUT output is compared each cycle against a
// reference model of the arbiter, which is built from the grant and shift
// rules using plain arithmetic.
module tb_shift_arbiter;

    logic clock;
    logic reset;

    shift_arbiter_if #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) bus ();

    shift_arbiter #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks_done;
    int checks_failed;

    // Reference model state
    logic        m_known;
    logic        m_last;
    logic [31:0] m_result;
    logic        m_valid;
    logic        m_src;
    logic        exp_gnt_a;
    logic        exp_gnt_b;
    int          wait_a;
    int          wait_b;

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_done++;
        if (actual !== expected) begin
            checks_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference shift: a left shift multiplies by 2^s modulo 2^32. An
    // arithmetic right shift is floor division by 2^s. A negative value is
    // handled as the complement of the complement divided.
    function automatic logic [31:0] model_shift(input logic [31:0] d, input logic [4:0] s,
                                                input logic dir);
        logic [63:0] p;
        logic [63:0] prod;
        logic [63:0] q;
        p = 64'd1;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(s)) p = p * 64'd2;
        end
        if (!dir) begin
            prod = {32'd0, d} * p;
            return prod[31:0];
        end
        if (!d[31]) begin
            q = {32'd0, d} / p;
            return q[31:0];
        end
        q = {32'd0, ~d} / p;
        return ~q[31:0];
    endfunction

    // One clock cycle: this task drives the inputs and checks the grants and
    // the registered outputs against the model. It then advances the model
    // across the edge. It returns 1ns after the edge.
    task automatic applyStimulus(input logic rst,
                                 input logic ra, input logic da, input logic [31:0] dta, input logic [4:0] sa,
                                 input logic rb, input logic db, input logic [31:0] dtb, input logic [4:0] sb);
        reset       = rst;
        bus.req_a   = ra;
        bus.dir_a   = da;
        bus.data_a  = dta;
        bus.shamt_a = sa;
        bus.req_b   = rb;
        bus.dir_b   = db;
        bus.data_b  = dtb;
        bus.shamt_b = sb;
        #1;
        if (rst) begin
            exp_gnt_a = 1'b0;
            exp_gnt_b = 1'b0;
        end else if (ra && rb) begin
            exp_gnt_a = m_last;
            exp_gnt_b = !m_last;
        end else begin
            exp_gnt_a = ra;
            exp_gnt_b = rb;
        end
        checkOutput("gnt_a", {31'd0, bus.gnt_a}, {31'd0, exp_gnt_a});
        checkOutput("gnt_b", {31'd0, bus.gnt_b}, {31'd0, exp_gnt_b});
        if (m_known) begin
            checkOutput("result_valid", {31'd0, bus.result_valid}, {31'd0, m_valid});
            checkOutput("result", bus.result, m_result);
            checkOutput("result_src", {31'd0, bus.result_src}, {31'd0, m_src});
        end
        if (!rst && ra) begin
            wait_a = bus.gnt_a ? 0 : wait_a + 1;
            checkOutput("wait_bound_a", {31'd0, wait_a < 2}, 32'd1);
        end else begin
            wait_a = 0;
        end
        if (!rst && rb) begin
            wait_b = bus.gnt_b ? 0 : wait_b + 1;
            checkOutput("wait_bound_b", {31'd0, wait_b < 2}, 32'd1);
        end else begin
            wait_b = 0;
        end
        if (rst) begin
            m_known  = 1'b1;
            m_last   = 1'b1;
            m_result = 32'd0;
            m_valid  = 1'b0;
            m_src    = 1'b0;
        end else if (exp_gnt_a) begin
            m_result = model_shift(dta, sa, da);
            m_valid  = 1'b1;
            m_src    = 1'b0;
            m_last   = 1'b0;
        end else if (exp_gnt_b) begin
            m_result = model_shift(dtb, sb, db);
            m_valid  = 1'b1;
            m_src    = 1'b1;
            m_last   = 1'b1;
        end else begin
            m_valid  = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    logic [31:0] held;
    logic        ra, da, rb, db, rst;
    logic [31:0] dta, dtb;
    logic [4:0]  sa, sb;

    // Directed scenarios followed by randomized traffic
    initial begin
        checks_done   = 0;
        checks_failed = 0;
        m_known  = 1'b0;
        m_last   = 1'b1;
        m_result = 32'd0;
        m_valid  = 1'b0;
        m_src    = 1'b0;
        wait_a   = 0;
        wait_b   = 0;
        reset    = 1'b1;
        #1;

        // Reset held two cycles while both requesters are asserting
        applyStimulus(1, 1, 0, 32'h1, 5'd1, 1, 0, 32'h2, 5'd2);
        applyStimulus(1, 1, 0, 32'h1, 5'd1, 1, 0, 32'h2, 5'd2);
        checkOutput("rst_result", bus.result, 32'd0);
        checkOutput("rst_valid", {31'd0, bus.result_valid}, 32'd0);
        checkOutput("rst_src", {31'd0, bus.result_src}, 32'd0);

        // A only: left shift by 31
        applyStimulus(0, 1, 0, 32'h0000_0001, 5'd31, 0, 0, 32'h0, 5'd0);
        checkOutput("a_left31", bus.result, 32'h8000_0000);
        checkOutput("a_left31_valid", {31'd0, bus.result_valid}, 32'd1);
        checkOutput("a_left31_src", {31'd0, bus.result_src}, 32'd0);

        // B only: arithmetic right by 4, then shift by zero
        applyStimulus(0, 0, 0, 32'h0, 5'd0, 1, 1, 32'h8000_00F0, 5'd4);
        checkOutput("b_right4", bus.result, 32'hF800_000F);
        checkOutput("b_right4_src", {31'd0, bus.result_src}, 32'd1);
        applyStimulus(0, 0, 0, 32'h0, 5'd0, 1, 1, 32'h1234_5678, 5'd0);
        checkOutput("b_shamt0", bus.result, 32'h1234_5678);

        // Right shift by 31 of a negative value
        applyStimulus(0, 1, 1, 32'h8000_0000, 5'd31, 0, 0, 32'h0, 5'd0);
        checkOutput("a_right31", bus.result, 32'hFFFF_FFFF);

        // Continuous tie straight after reset: grants alternate A, B, A, ...
        applyStimulus(1, 0, 0, 32'h0, 5'd0, 0, 0, 32'h0, 5'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 0, 32'h10 + i, 5'd1, 1, 1, 32'hF000_0000 + i, 5'd2);
            checkOutput("alt_src", {31'd0, bus.result_src}, i % 2);
            checkOutput("alt_valid", {31'd0, bus.result_valid}, 32'd1);
        end

        // Idle gap: the result holds and the next tie goes to the other side
        applyStimulus(0, 1, 0, 32'h0000_00AB, 5'd4, 0, 0, 32'h0, 5'd0);
        held = bus.result;
        applyStimulus(0, 0, 0, 32'h0, 5'd0, 0, 0, 32'h0, 5'd0);
        checkOutput("idle_valid", {31'd0, bus.result_valid}, 32'd0);
        checkOutput("idle_hold", bus.result, 32'h0000_0AB0);
        checkOutput("idle_hold_model", held, 32'h0000_0AB0);
        applyStimulus(0, 1, 0, 32'h1, 5'd1, 1, 0, 32'h3, 5'd1);
        checkOutput("tie_after_a", {31'd0, bus.result_src}, 32'd1);

        // A request in a reset cycle is discarded, and A then wins the tie
        applyStimulus(1, 1, 0, 32'h5, 5'd3, 0, 0, 32'h0, 5'd0);
        checkOutput("rstmid_valid", {31'd0, bus.result_valid}, 32'd0);
        applyStimulus(0, 1, 0, 32'h5, 5'd3, 1, 0, 32'h7, 5'd1);
        checkOutput("rstmid_tie_src", {31'd0, bus.result_src}, 32'd0);
        checkOutput("rstmid_tie_res", bus.result, 32'h28);

        // Randomized traffic: requesters hold req and operands until granted
        ra = 0; rb = 0; da = 0; db = 0; dta = 0; dtb = 0; sa = 0; sb = 0;
        exp_gnt_a = 0; exp_gnt_b = 0;
        for (int i = 0; i < 400; i++) begin
            if (!ra || exp_gnt_a) begin
                ra  = ($urandom_range(0, 9) < 6);
                da  = $urandom_range(0, 1) == 1;
                dta = $urandom;
                sa  = 5'($urandom_range(0, 31));
            end
            if (!rb || exp_gnt_b) begin
                rb  = ($urandom_range(0, 9) < 6);
                db  = $urandom_range(0, 1) == 1;
                dtb = $urandom;
                sb  = 5'($urandom_range(0, 31));
            end
            rst = ($urandom_range(0, 49) == 0);
            applyStimulus(rst, ra, da, dta, sa, rb, db, dtb, sb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end

endmodule
